// File: rtl/port_shifter.sv
// Frame engine that mirrors the core's port A/B registers into a 74HC595 chain
// and collects external pin levels from a 74HC165 chain into PAI/PBI.
module port_shifter #(
  parameter int unsigned DIV = 2
) (
  input  logic       phi2,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] PAO,
  input  logic [7:0] DDRA,
  input  logic [7:0] PBO,
  input  logic [7:0] DDRB,
  output logic [7:0] PAI,
  output logic [7:0] PBI,
  output logic       ser_out,
  output logic       sclk,
  output logic       rclk,
  output logic       ld_n,
  input  logic       ser_in,
  output logic       busy,
  output logic       frame_done
);

  if (DIV < 1 || DIV > 255) begin : g_div_chk
    $error("port_shifter: DIV out of range");
  end

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_e;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic [31:0] outsr_q, outsr_d;
  logic [15:0] insr_q, insr_d;
  logic [7:0]  pai_q, pai_d, pbi_q, pbi_d;
  logic        ser_out_q, ser_out_d;
  logic        sclk_q, sclk_d;
  logic        rclk_q, rclk_d;
  logic        ld_n_q, ld_n_d;
  logic        busy_q, busy_d;
  logic        fdone_q, fdone_d;
  logic        phase_end;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_idx_d = bit_idx_q;
    outsr_d   = outsr_q;
    insr_d    = insr_q;
    pai_d     = pai_q;
    pbi_d     = pbi_q;
    ser_out_d = ser_out_q;
    fdone_d   = 1'b0;
    phase_end = (div_cnt_q == DIV_LAST);

    // IDLE reacts on the very next edge; every other state lasts DIV cycles
    if (state_q != IDLE)
      div_cnt_d = phase_end ? 8'd0 : div_cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = LOAD;
          outsr_d = {DDRB, PBO, DDRA, PAO};
        end
      end
      LOAD: begin
        if (phase_end) begin
          state_d   = SHIFT_LO;
          bit_idx_d = 5'd0;
          ser_out_d = outsr_q[31];
        end
      end
      SHIFT_LO: begin
        if (phase_end) begin
          state_d = SHIFT_HI;
          // only the first 16 slots carry pin data; the rest of the 165 chain is don't-care
          if (!bit_idx_q[4])
            insr_d = {insr_q[14:0], ser_in};
        end
      end
      SHIFT_HI: begin
        if (phase_end) begin
          if (bit_idx_q == 5'd31) begin
            state_d = LATCH;
          end else begin
            state_d   = SHIFT_LO;
            bit_idx_d = bit_idx_q + 5'd1;
            ser_out_d = outsr_q[5'd31 - bit_idx_d];
          end
        end
      end
      LATCH: begin
        if (phase_end) begin
          pbi_d   = insr_q[15:8];
          pai_d   = insr_q[7:0];
          fdone_d = 1'b1;
          if (en) begin
            state_d = LOAD;
            outsr_d = {DDRB, PBO, DDRA, PAO};
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // strobes follow the next state so every pin is a flop output
    sclk_d = (state_d == SHIFT_HI);
    rclk_d = (state_d == LATCH);
    ld_n_d = (state_d != LOAD);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_idx_q <= '0;
      outsr_q   <= '0;
      insr_q    <= '0;
      pai_q     <= '0;
      pbi_q     <= '0;
      ser_out_q <= 1'b0;
      sclk_q    <= 1'b0;
      rclk_q    <= 1'b0;
      ld_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_idx_q <= bit_idx_d;
      outsr_q   <= outsr_d;
      insr_q    <= insr_d;
      pai_q     <= pai_d;
      pbi_q     <= pbi_d;
      ser_out_q <= ser_out_d;
      sclk_q    <= sclk_d;
      rclk_q    <= rclk_d;
      ld_n_q    <= ld_n_d;
      busy_q    <= busy_d;
      fdone_q   <= fdone_d;
    end
  end

  assign PAI        = pai_q;
  assign PBI        = pbi_q;
  assign ser_out    = ser_out_q;
  assign sclk       = sclk_q;
  assign rclk       = rclk_q;
  assign ld_n       = ld_n_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_port_shifter.sv
// Directed bench for port_shifter: table of whole frames plus hand sequences for
// snapshot, enable drop and mid-frame reset, with a behavioural 165 chain.
module tb_port_shifter;
  localparam int DIV = 2;

  logic       phi2 = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] pao = '0, ddra = '0, pbo = '0, ddrb = '0;
  logic [7:0] PAI, PBI;
  logic       ser_out, sclk, rclk, ld_n, ser_in, busy, frame_done;

  logic [15:0] pins = '0;
  logic [15:0] sr165 = '0;
  logic        sclk_d = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  pao, ddra, pbo, ddrb;
    logic [15:0] pins;
    logic [31:0] stream;
    logic [7:0]  pai, pbi;
  } vec_t;
  vec_t tbl[4];

  port_shifter #(.DIV(DIV)) dut (
    .phi2(phi2), .rst_n(rst_n), .en(en),
    .PAO(pao), .DDRA(ddra), .PBO(pbo), .DDRB(ddrb),
    .PAI(PAI), .PBI(PBI), .ser_out(ser_out), .sclk(sclk), .rclk(rclk),
    .ld_n(ld_n), .ser_in(ser_in), .busy(busy), .frame_done(frame_done)
  );

  always #5 phi2 = ~phi2;

  // 74HC165 model: parallel load while ld_n low, shift after each rising sclk
  always @(posedge phi2) begin
    if (!ld_n) sr165 <= pins;
    else if (sclk && !sclk_d) sr165 <= {sr165[14:0], 1'b0};
    sclk_d <= sclk;
  end
  assign ser_in = sr165[15];

  function automatic logic [21:0] outs();
    return {sclk, rclk, ld_n, ser_out, busy, frame_done, PBI, PAI};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic wait_ld(output int cyc);
    cyc = 999;
    for (int i = 1; i <= 50; i++) begin
      @(posedge phi2); #1;
      if (!ld_n) begin
        cyc = i;
        return;
      end
    end
  endtask

  // Starts on the first LOAD cycle; ends on the frame_done cycle (len=-1 on timeout).
  // act: 1 = PAO<=FF, 2 = drop en, 3 = assert reset, fired after act_at sclk rises.
  task automatic do_frame(input int act_at, input int act, output logic [31:0] stream,
                          output int nsclk, output int nrclk, output int len, output bit stable);
    logic prev;
    logic [7:0] pai0, pbi0;
    prev = sclk; pai0 = PAI; pbi0 = PBI;
    stream = '0; nsclk = 0; nrclk = 0; len = -1; stable = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge phi2); #1;
      if (frame_done) begin
        len = i;
        return;
      end
      if (PAI !== pai0 || PBI !== pbi0) stable = 1'b0;
      if (rclk) nrclk++;
      if (sclk && !prev) begin
        stream = {stream[30:0], ser_out};
        nsclk++;
        if (nsclk == act_at) begin
          if (act == 1) pao = 8'hFF;
          if (act == 2) en = 1'b0;
          if (act == 3) begin
            rst_n = 1'b0;
            #1;
            return;
          end
        end
      end
      prev = sclk;
    end
  endtask

  task automatic check_frame(input string tag, input logic [31:0] stream, input int nsclk,
                             input int nrclk, input int len, input bit stable,
                             input logic [31:0] exp_stream, input logic [7:0] epai,
                             input logic [7:0] epbi);
    chk({tag, ".stream"}, stream, exp_stream);
    chk({tag, ".sclk_pulses"}, nsclk, 32);
    chk({tag, ".rclk_cycles"}, nrclk, DIV);
    chk({tag, ".frame_len"}, len, 66 * DIV);
    chk({tag, ".pin_hold"}, {31'd0, stable}, 32'd1);
    chk({tag, ".pins_in"}, {16'd0, PBI, PAI}, {16'd0, epbi, epai});
  endtask

  initial begin
    logic [31:0] stream;
    int nsclk, nrclk, len, cyc, cnt;
    bit stable;

    tbl[0] = '{pao:8'hA5, ddra:8'h0F, pbo:8'h3C, ddrb:8'hFF, pins:16'hC35A,
               stream:32'hFF3C0FA5, pai:8'h5A, pbi:8'hC3};
    tbl[1] = '{pao:8'h00, ddra:8'h00, pbo:8'h00, ddrb:8'h00, pins:16'hFFFF,
               stream:32'h00000000, pai:8'hFF, pbi:8'hFF};
    tbl[2] = '{pao:8'h01, ddra:8'h80, pbo:8'h00, ddrb:8'h01, pins:16'h8001,
               stream:32'h01008001, pai:8'h01, pbi:8'h80};
    tbl[3] = '{pao:8'h12, ddra:8'h34, pbo:8'h56, ddrb:8'h78, pins:16'h1234,
               stream:32'h78563412, pai:8'h34, pbi:8'h12};

    // reset held with en high
    pao = tbl[0].pao; ddra = tbl[0].ddra; pbo = tbl[0].pbo; ddrb = tbl[0].ddrb;
    pins = tbl[0].pins; en = 1'b1;
    repeat (4) @(posedge phi2);
    #1;
    chk("reset_outs", {10'd0, outs()}, {10'd0, 22'b0_0_1_0_0_0_00000000_00000000});
    rst_n = 1'b1;
    @(posedge phi2); #1;
    chk("release_ld_n_busy", {30'd0, ld_n, busy}, {30'd0, 1'b0, 1'b1});
    en = 1'b0;
    do_frame(0, 0, stream, nsclk, nrclk, len, stable);
    check_frame("first", stream, nsclk, nrclk, len, stable, 32'hFF3C0FA5, 8'h5A, 8'hC3);

    // single frames from IDLE
    for (int v = 0; v < 4; v++) begin
      @(posedge phi2); #1;
      pao = tbl[v].pao; ddra = tbl[v].ddra; pbo = tbl[v].pbo; ddrb = tbl[v].ddrb;
      pins = tbl[v].pins; en = 1'b1;
      wait_ld(cyc);
      chk($sformatf("v%0d.ld_latency", v), cyc, 1);
      en = 1'b0;
      do_frame(0, 0, stream, nsclk, nrclk, len, stable);
      check_frame($sformatf("v%0d", v), stream, nsclk, nrclk, len, stable,
                  tbl[v].stream, tbl[v].pai, tbl[v].pbi);
      chk($sformatf("v%0d.idle_after", v), {30'd0, busy, ld_n}, {30'd0, 1'b0, 1'b1});
      @(posedge phi2); #1;
      chk($sformatf("v%0d.fdone_pulse", v), {31'd0, frame_done}, 32'd0);
    end

    // snapshot: PAO changes mid-frame, then en drops in the next frame
    pao = 8'h00; ddra = 8'h00; pbo = 8'h00; ddrb = 8'h00; pins = 16'h0F0F; en = 1'b1;
    wait_ld(cyc);
    chk("snap.ld_latency", cyc, 1);
    do_frame(11, 1, stream, nsclk, nrclk, len, stable);
    check_frame("snap0", stream, nsclk, nrclk, len, stable, 32'h00000000, 8'h0F, 8'h0F);
    chk("snap.back_to_back", {30'd0, ld_n, busy}, {30'd0, 1'b0, 1'b1});
    do_frame(21, 2, stream, nsclk, nrclk, len, stable);
    check_frame("snap1", stream, nsclk, nrclk, len, stable, 32'h000000FF, 8'h0F, 8'h0F);
    chk("drop.busy", {31'd0, busy}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge phi2); #1;
      if (!ld_n || busy) cnt++;
    end
    chk("drop.no_reload", cnt, 0);

    // asynchronous reset at bit 25 of a back-to-back frame
    pao = tbl[0].pao; ddra = tbl[0].ddra; pbo = tbl[0].pbo; ddrb = tbl[0].ddrb;
    pins = tbl[0].pins; en = 1'b1;
    wait_ld(cyc);
    do_frame(0, 0, stream, nsclk, nrclk, len, stable);
    check_frame("pre_rst", stream, nsclk, nrclk, len, stable, 32'hFF3C0FA5, 8'h5A, 8'hC3);
    do_frame(26, 3, stream, nsclk, nrclk, len, stable);
    chk("arst.outs", {10'd0, outs()}, {10'd0, 22'b0_0_1_0_0_0_00000000_00000000});
    repeat (3) @(posedge phi2);
    #1;
    rst_n = 1'b1;
    wait_ld(cyc);
    chk("arst.restart_latency", cyc, 1);
    en = 1'b0;
    do_frame(0, 0, stream, nsclk, nrclk, len, stable);
    check_frame("post_rst", stream, nsclk, nrclk, len, stable, 32'hFF3C0FA5, 8'h5A, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
